// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED PWM fader.
// Optional gamma mapping is compiled in with `define LED_FADER_GAMMA_EN.
package led_pkg;

    localparam int unsigned LED_COUNT     = 6;
    localparam int unsigned PWM_BITS_DEF  = 8;
    localparam int unsigned FADE_DIV_DEF  = 52_000;
    localparam int unsigned FADE_STEP_DEF = 1;

`ifdef LED_FADER_GAMMA_EN
    // Quadratic perceptual curve: (d * (d + 2)) >> bits; keeps 0 -> 0 and all-ones -> all-ones.
    function automatic logic [31:0] gamma_map(input logic [15:0] duty, input int unsigned bits);
        logic [32:0] prod;
        prod = 33'(duty) * (33'(duty) + 33'd2);
        return 32'(prod >> bits);
    endfunction
`endif

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: duty register with load/fade, optional gamma, PWM compare and output flop.
// Gamma mapping enabled by `define LED_FADER_GAMMA_EN.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
    parameter int unsigned FADE_STEP = FADE_STEP_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                led_in,
    input  logic                fade_en,
    input  logic                fade_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_n
);

    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);
    localparam logic [PWM_BITS-1:0] FULL = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] eff;

    // Duty update: lit channel loads full, disabled fade clears, tick decrements with floor at 0.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            duty <= '0;
        end else if (led_in) begin
            duty <= FULL;
        end else if (!fade_en) begin
            duty <= '0;
        end else if (fade_tick) begin
            duty <= (duty < STEP) ? '0 : duty - STEP;
        end
    end

`ifdef LED_FADER_GAMMA_EN
    // Perceptual mapping of the linear duty.
    always_comb begin
        eff = PWM_BITS'(gamma_map(16'(duty), PWM_BITS));
    end
`else
    // Linear brightness: effective duty is the duty register itself.
    always_comb begin
        eff = duty;
    end
`endif

    // Registered active-low output; pwm_cnt never reaches all-ones so full duty is always on.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            led_n <= 1'b1;
        end else begin
            led_n <= !(pwm_cnt < eff);
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// Six-channel PWM LED driver with linear fade-out trails behind the rotating pattern.
// Shared fade prescaler and PWM counter; per-channel logic in led_pwm_channel.
// Gamma mapping enabled by `define LED_FADER_GAMMA_EN.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
    parameter int unsigned FADE_DIV  = FADE_DIV_DEF,
    parameter int unsigned FADE_STEP = FADE_STEP_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [5:0] led_in,
    input  logic       fade_en,
    output logic [5:0] led_n
);

    localparam int unsigned         DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [DIV_W-1:0]    div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                fade_tick;

    assign fade_tick = (div_cnt == DIV_LAST);

    // Fade prescaler: 0 .. FADE_DIV-1, tick on the last count.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            div_cnt <= '0;
        end else if (fade_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // PWM counter: 0 .. 2^PWM_BITS-2, skipping all-ones.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // One independent channel per LED.
    for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .led_in    (led_in[i]),
            .fade_en   (fade_en),
            .fade_tick (fade_tick),
            .pwm_cnt   (pwm_cnt),
            .led_n     (led_n[i])
        );
    end

endmodule
